// File: rtl/mips_pkg.sv
// rtl/mips_pkg.sv - shared MIPS opcodes, control bundle layout and ALUOp codes
package mips_pkg;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;
  localparam logic [5:0] OP_BEQ   = 6'h04;

  localparam int WB_W = 2;
  localparam int M_W  = 3;
  localparam int EX_W = 4;

  localparam int WB_REGWRITE = 1;
  localparam int WB_MEMTOREG = 0;
  localparam int M_BRANCH    = 2;
  localparam int M_MEMREAD   = 1;
  localparam int M_MEMWRITE  = 0;
  localparam int EX_REGDST   = 3;
  localparam int EX_ALUOP_HI = 2;
  localparam int EX_ALUOP_LO = 1;
  localparam int EX_ALUSRC   = 0;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  typedef struct packed {
    logic [WB_W-1:0] wb;
    logic [M_W-1:0]  m;
    logic [EX_W-1:0] ex;
  } ctrl_t;

  function automatic logic [31:0] sign_ext16(input logic [15:0] v);
    return {{16{v[15]}}, v};
  endfunction

endpackage

// File: rtl/reg_file.sv
// rtl/reg_file.sv - 32x32 register file, 2 read / 1 write; I_DECODE_WB_FORWARD_EN makes it write-first
module reg_file
  import mips_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic [4:0]  rs,
  input  logic [4:0]  rt,
  output logic [31:0] rs_data,
  output logic [31:0] rt_data,
  input  logic        we,
  input  logic [4:0]  wa,
  input  logic [31:0] wd
);

  logic [31:0] regs [32];
  logic        wr_ok;

  assign wr_ok = we && (wa != 5'd0);

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 32; i++) regs[i] <= '0;
    end else if (wr_ok) begin
      regs[wa] <= wd;
    end
  end

`ifdef I_DECODE_WB_FORWARD_EN
  // wr_ok already excludes r0, so r0 can never pick up forwarded data
  assign rs_data = (rs == 5'd0) ? '0 : (wr_ok && wa == rs) ? wd : regs[rs];
  assign rt_data = (rt == 5'd0) ? '0 : (wr_ok && wa == rt) ? wd : regs[rt];
`else
  assign rs_data = (rs == 5'd0) ? '0 : regs[rs];
  assign rt_data = (rt == 5'd0) ? '0 : regs[rt];
`endif

endmodule

// File: rtl/i_decode.sv
// rtl/i_decode.sv - MIPS ID stage: control decode, register read, ID/EX latch (I_DECODE_WB_FORWARD_EN)
module i_decode
  import mips_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] IF_ID_IR,
  input  logic [31:0] IF_ID_NPC,
  input  logic        ID_flush,
  input  logic        MEM_WB_RegWrite,
  input  logic [4:0]  MEM_WB_rd,
  input  logic [31:0] WB_data,
  output logic [1:0]  ID_EX_WB,
  output logic [2:0]  ID_EX_M,
  output logic [3:0]  ID_EX_EX,
  output logic [31:0] ID_EX_NPC,
  output logic [31:0] ID_EX_A,
  output logic [31:0] ID_EX_B,
  output logic [31:0] ID_EX_imm,
  output logic [4:0]  ID_EX_rt,
  output logic [4:0]  ID_EX_rd
);

  logic [5:0]  opcode;
  logic [4:0]  rs, rt, rd;
  logic [31:0] rs_data, rt_data;
  ctrl_t       ctrl;

  assign opcode = IF_ID_IR[31:26];
  assign rs     = IF_ID_IR[25:21];
  assign rt     = IF_ID_IR[20:16];
  assign rd     = IF_ID_IR[15:11];

  reg_file u_reg_file (
    .clk     (clk),
    .rst     (rst),
    .rs      (rs),
    .rt      (rt),
    .rs_data (rs_data),
    .rt_data (rt_data),
    .we      (MEM_WB_RegWrite),
    .wa      (MEM_WB_rd),
    .wd      (WB_data)
  );

  always_comb begin
    ctrl = '0;
    case (opcode)
      OP_RTYPE: begin
        ctrl.wb[WB_REGWRITE]               = 1'b1;
        ctrl.ex[EX_REGDST]                 = 1'b1;
        ctrl.ex[EX_ALUOP_HI:EX_ALUOP_LO]   = ALUOP_FUNCT;
      end
      OP_LW: begin
        ctrl.wb[WB_REGWRITE]               = 1'b1;
        ctrl.wb[WB_MEMTOREG]               = 1'b1;
        ctrl.m[M_MEMREAD]                  = 1'b1;
        ctrl.ex[EX_ALUOP_HI:EX_ALUOP_LO]   = ALUOP_ADD;
        ctrl.ex[EX_ALUSRC]                 = 1'b1;
      end
      OP_SW: begin
        ctrl.m[M_MEMWRITE]                 = 1'b1;
        ctrl.ex[EX_ALUOP_HI:EX_ALUOP_LO]   = ALUOP_ADD;
        ctrl.ex[EX_ALUSRC]                 = 1'b1;
      end
      OP_BEQ: begin
        ctrl.m[M_BRANCH]                   = 1'b1;
        ctrl.ex[EX_ALUOP_HI:EX_ALUOP_LO]   = ALUOP_SUB;
      end
      default: ctrl = '0;
    endcase
  end

  // flush only squashes control; data fields still advance
  always_ff @(posedge clk) begin
    if (rst) begin
      ID_EX_WB  <= '0;
      ID_EX_M   <= '0;
      ID_EX_EX  <= '0;
      ID_EX_NPC <= '0;
      ID_EX_A   <= '0;
      ID_EX_B   <= '0;
      ID_EX_imm <= '0;
      ID_EX_rt  <= '0;
      ID_EX_rd  <= '0;
    end else begin
      ID_EX_WB  <= ID_flush ? '0 : ctrl.wb;
      ID_EX_M   <= ID_flush ? '0 : ctrl.m;
      ID_EX_EX  <= ID_flush ? '0 : ctrl.ex;
      ID_EX_NPC <= IF_ID_NPC;
      ID_EX_A   <= rs_data;
      ID_EX_B   <= rt_data;
      ID_EX_imm <= sign_ext16(IF_ID_IR[15:0]);
      ID_EX_rt  <= rt;
      ID_EX_rd  <= rd;
    end
  end

endmodule

// File: tb/tb_i_decode.sv
// tb/tb_i_decode.sv - self-checking bench for i_decode (vectors, corner sequences, random vs model)
module tb_i_decode;

`ifdef I_DECODE_WB_FORWARD_EN
  localparam bit FWD = 1'b1;
`else
  localparam bit FWD = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] ir, npc, wdata;
  logic        flush, we;
  logic [4:0]  wrd;
  logic [1:0]  o_wb;
  logic [2:0]  o_m;
  logic [3:0]  o_ex;
  logic [31:0] o_npc, o_a, o_b, o_imm;
  logic [4:0]  o_rt, o_rd;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  i_decode dut (
    .clk             (clk),
    .rst             (rst),
    .IF_ID_IR        (ir),
    .IF_ID_NPC       (npc),
    .ID_flush        (flush),
    .MEM_WB_RegWrite (we),
    .MEM_WB_rd       (wrd),
    .WB_data         (wdata),
    .ID_EX_WB        (o_wb),
    .ID_EX_M         (o_m),
    .ID_EX_EX        (o_ex),
    .ID_EX_NPC       (o_npc),
    .ID_EX_A         (o_a),
    .ID_EX_B         (o_b),
    .ID_EX_imm       (o_imm),
    .ID_EX_rt        (o_rt),
    .ID_EX_rd        (o_rd)
  );

  typedef struct {
    logic [1:0]  wb;
    logic [2:0]  m;
    logic [3:0]  ex;
    logic [31:0] npc, a, b, imm;
    logic [4:0]  rt, rd;
  } exp_t;

  typedef struct {
    logic [31:0] ir, npc;
    logic        flush, we;
    logic [4:0]  wrd;
    logic [31:0] wdata;
    exp_t        e;
  } vec_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  task automatic chk_out(input string tag, input exp_t e);
    chk({tag, ".wb"},  32'(o_wb),  32'(e.wb));
    chk({tag, ".m"},   32'(o_m),   32'(e.m));
    chk({tag, ".ex"},  32'(o_ex),  32'(e.ex));
    chk({tag, ".npc"}, o_npc, e.npc);
    chk({tag, ".a"},   o_a,   e.a);
    chk({tag, ".b"},   o_b,   e.b);
    chk({tag, ".imm"}, o_imm, e.imm);
    chk({tag, ".rt"},  32'(o_rt),  32'(e.rt));
    chk({tag, ".rd"},  32'(o_rd),  32'(e.rd));
  endtask

  task automatic drive(input logic [31:0] i, input logic [31:0] n, input logic f,
                       input logic w, input logic [4:0] r, input logic [31:0] d);
    ir = i; npc = n; flush = f; we = w; wrd = r; wdata = d;
  endtask

  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  // Control table straight from the ISA decode table: {WB, M, EX}
  function automatic logic [8:0] ctrl_of(input logic [5:0] op);
    case (op)
      6'h00:   return {2'b10, 3'b000, 4'b1100};
      6'h23:   return {2'b11, 3'b010, 4'b0001};
      6'h2B:   return {2'b00, 3'b001, 4'b0001};
      6'h04:   return {2'b00, 3'b100, 4'b0010};
      default: return 9'd0;
    endcase
  endfunction

  vec_t        vecs[10];
  exp_t        zero_e, e;
  logic [31:0] rf[32];
  logic [31:0] rnd;
  logic [5:0]  op;
  logic [8:0]  c;
  logic [4:0]  rs_i, rt_i;

  initial begin
    zero_e = '{wb: 0, m: 0, ex: 0, npc: 0, a: 0, b: 0, imm: 0, rt: 0, rd: 0};

    vecs[0] = '{32'h0000_0000, 32'h04, 1'b0, 1'b1, 5'd8, 32'hAA,
                '{2'b10, 3'b000, 4'b1100, 32'h04, 32'h0, 32'h0, 32'h0, 5'd0, 5'd0}};
    vecs[1] = '{32'h0000_0000, 32'h08, 1'b0, 1'b1, 5'd9, 32'h11,
                '{2'b10, 3'b000, 4'b1100, 32'h08, 32'h0, 32'h0, 32'h0, 5'd0, 5'd0}};
    vecs[2] = '{32'h0109_5020, 32'h24, 1'b0, 1'b0, 5'd0, 32'h0,
                '{2'b10, 3'b000, 4'b1100, 32'h24, 32'hAA, 32'h11, 32'h5020, 5'd9, 5'd10}};
    vecs[3] = '{32'h8D09_FFFC, 32'h28, 1'b0, 1'b0, 5'd0, 32'h0,
                '{2'b11, 3'b010, 4'b0001, 32'h28, 32'hAA, 32'h11, 32'hFFFF_FFFC, 5'd9, 5'd31}};
    vecs[4] = '{32'h0000_0020, 32'h2C, 1'b0, 1'b1, 5'd0, 32'h1234,
                '{2'b10, 3'b000, 4'b1100, 32'h2C, 32'h0, 32'h0, 32'h20, 5'd0, 5'd0}};
    vecs[5] = '{32'h0000_0020, 32'h30, 1'b0, 1'b0, 5'd0, 32'h0,
                '{2'b10, 3'b000, 4'b1100, 32'h30, 32'h0, 32'h0, 32'h20, 5'd0, 5'd0}};
    vecs[6] = '{32'h1109_000C, 32'h34, 1'b1, 1'b0, 5'd0, 32'h0,
                '{2'b00, 3'b000, 4'b0000, 32'h34, 32'hAA, 32'h11, 32'hC, 5'd9, 5'd0}};
    vecs[7] = '{32'h1109_000C, 32'h38, 1'b0, 1'b0, 5'd0, 32'h0,
                '{2'b00, 3'b100, 4'b0010, 32'h38, 32'hAA, 32'h11, 32'hC, 5'd9, 5'd0}};
    vecs[8] = '{32'hAD09_0004, 32'h3C, 1'b0, 1'b0, 5'd0, 32'h0,
                '{2'b00, 3'b001, 4'b0001, 32'h3C, 32'hAA, 32'h11, 32'h4, 5'd9, 5'd0}};
    vecs[9] = '{32'h2109_8005, 32'h40, 1'b0, 1'b0, 5'd0, 32'h0,
                '{2'b00, 3'b000, 4'b0000, 32'h40, 32'hAA, 32'h11, 32'hFFFF_8005, 5'd9, 5'd16}};

    // Reset held two cycles with an lw presented and a write-back to r5 that must be dropped
    rst = 1'b1;
    drive(32'h8D09_FFFC, 32'h100, 1'b0, 1'b1, 5'd5, 32'hDEAD_BEEF);
    cycle(); chk_out("reset0", zero_e);
    cycle(); chk_out("reset1", zero_e);
    rst = 1'b0;
    drive(32'h0000_0000, 32'h0, 1'b0, 1'b0, 5'd0, 32'h0);
    for (int i = 1; i < 32; i++) begin
      ir = {6'h00, 5'(i), 5'(i), 16'h0};
      cycle();
      chk($sformatf("post_reset_r%0d.a", i), o_a, 32'h0);
      chk($sformatf("post_reset_r%0d.b", i), o_b, 32'h0);
    end

    for (int i = 0; i < 10; i++) begin
      drive(vecs[i].ir, vecs[i].npc, vecs[i].flush, vecs[i].we, vecs[i].wrd, vecs[i].wdata);
      cycle();
      chk_out($sformatf("vec%0d", i), vecs[i].e);
    end

    // Same-cycle write-back and read of r8
    drive(32'h0000_0000, 32'h50, 1'b0, 1'b1, 5'd8, 32'h5);
    cycle();
    drive(32'h0109_5020, 32'h54, 1'b0, 1'b1, 5'd8, 32'h7);
    cycle();
    chk("same_cycle.a", o_a, FWD ? 32'h7 : 32'h5);
    chk("same_cycle.b", o_b, 32'h11);
    drive(32'h0109_5020, 32'h58, 1'b0, 1'b0, 5'd0, 32'h0);
    cycle();
    chk("after_write.a", o_a, 32'h7);

    // Same-cycle write of r0 while reading r0
    drive(32'h0000_0020, 32'h5C, 1'b0, 1'b1, 5'd0, 32'hFFFF_FFFF);
    cycle();
    chk("r0_same_cycle.a", o_a, 32'h0);
    chk("r0_same_cycle.b", o_b, 32'h0);

    // Mid-run reset together with flush and a write-back: reset wins, registers clear
    rst = 1'b1;
    drive(32'h0109_5020, 32'h60, 1'b1, 1'b1, 5'd9, 32'h99);
    cycle(); chk_out("mid_reset", zero_e);
    rst = 1'b0;
    drive(32'h0109_5020, 32'h64, 1'b0, 1'b0, 5'd0, 32'h0);
    cycle();
    chk_out("after_mid_reset",
            '{2'b10, 3'b000, 4'b1100, 32'h64, 32'h0, 32'h0, 32'h5020, 5'd9, 5'd10});

    // Random traffic against an architectural model of the stage
    for (int i = 0; i < 32; i++) rf[i] = '0;
    for (int n = 0; n < 400; n++) begin
      case ($urandom_range(0, 5))
        0: op = 6'h00;
        1: op = 6'h23;
        2: op = 6'h2B;
        3: op = 6'h04;
        default: op = 6'($urandom());
      endcase
      rnd = $urandom();
      rst = ($urandom_range(0, 39) == 0);
      drive({op, rnd[25:0]}, $urandom(), ($urandom_range(0, 3) == 0),
            $urandom_range(0, 1) == 1, 5'($urandom_range(0, 31)), $urandom());
      if (rnd[0]) wrd = rnd[25:21];
      rs_i = ir[25:21];
      rt_i = ir[20:16];
      if (rst) begin
        e = zero_e;
        for (int i = 0; i < 32; i++) rf[i] = '0;
      end else begin
        c = flush ? 9'd0 : ctrl_of(op);
        e.wb = c[8:7]; e.m = c[6:4]; e.ex = c[3:0];
        e.npc = npc;
        e.a = (rs_i == 0) ? 32'h0 : (FWD && we && wrd != 0 && wrd == rs_i) ? wdata : rf[rs_i];
        e.b = (rt_i == 0) ? 32'h0 : (FWD && we && wrd != 0 && wrd == rt_i) ? wdata : rf[rt_i];
        e.imm = 32'($signed(ir[15:0]));
        e.rt = rt_i;
        e.rd = ir[15:11];
        if (we && wrd != 0) rf[wrd] = wdata;
      end
      cycle();
      chk_out($sformatf("rand%0d", n), e);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
